cpu_mem_arbiter: RTL and testbench

- Shares one single-port, pipelined memory between the core's instruction-fetch (IF) requester and its data-memory (DM) load/store requester.
- Sits between the core pipeline and a unified instruction/data SRAM or bus bridge.
- Arbitrates requests, holds the memory request stable until accepted, tracks outstanding transactions, and routes in-order responses back to their owner.
- The pipeline hazard logic stalls on a missing grant.

---
 rtl/cpu_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one pipelined single-port memory between the
// instruction-fetch (IF) and data-memory (DM) requesters of the core.
// A request is presented combinationally in IDLE and held in HOLD until the
// memory grants it. An in-order tracker routes responses back to their owner.
// Optional build macro CPU_MEM_ARB_RR_EN: round-robin arbitration replaces
// DM priority with STARVE_LIMIT anti-starvation.
module cpu_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [3:0]  i_dm_be,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;
  typedef enum logic {OWN_DM = 1'b0, OWN_IF = 1'b1} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  owner_t        winner;
  owner_t        cur_owner;
  logic          mem_req;
  logic          accept;
  logic          push, pop;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  owner_t        fifo_own_q [MAX_OUTSTANDING];
  logic          fifo_st_q  [MAX_OUTSTANDING];
  owner_t        head_own;
  logic          head_st;
  logic          err_q;

`ifdef CPU_MEM_ARB_RR_EN
  owner_t last_q;

  // Round-robin pick: on contention the side not granted last time wins
  always_comb begin
    winner = OWN_DM;
    if (i_dm_req && i_if_req) begin
      winner = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (i_if_req) begin
      winner = OWN_IF;
    end
  end

  // Remember the owner of the most recent accept; reset favours DM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= OWN_IF;
    end else if (accept) begin
      last_q <= cur_owner;
    end
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  // DM priority pick, overridden once IF has lost STARVE_LIMIT cycles in a row
  always_comb begin
    winner = OWN_DM;
    if (i_dm_req && !(i_if_req && (starve_q == SW'(STARVE_LIMIT)))) begin
      winner = OWN_DM;
    end else if (i_if_req) begin
      winner = OWN_IF;
    end
  end

  // Count consecutive cycles with a pending but unaccepted IF request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (!i_if_req || (accept && (cur_owner == OWN_IF))) begin
      starve_q <= '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`endif

  // State and latched owner registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_DM;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state: issue from IDLE when a slot is free, hold until granted
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mem_req   = 1'b0;
    cur_owner = owner_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != CW'(MAX_OUTSTANDING)) && (i_dm_req || i_if_req)) begin
          mem_req   = 1'b1;
          cur_owner = winner;
          if (!i_mem_gnt) begin
            state_d = S_HOLD;
            owner_d = winner;
          end
        end
      end
      S_HOLD: begin
        mem_req = 1'b1;
        if (i_mem_gnt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept   = mem_req && i_mem_gnt;
  assign push     = accept;
  assign pop      = i_mem_rvalid && (count_q != '0);
  assign head_own = fifo_own_q[rd_ptr_q];
  assign head_st  = fifo_st_q[rd_ptr_q];

  // Memory-side request fields and grant / response routing
  always_comb begin
    o_mem_req   = mem_req;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (mem_req) begin
      if (cur_owner == OWN_DM) begin
        o_mem_we    = i_dm_we;
        o_mem_be    = i_dm_be;
        o_mem_addr  = i_dm_addr;
        o_mem_wdata = i_dm_wdata;
      end else begin
        o_mem_be    = '1;
        o_mem_addr  = i_if_addr;
      end
    end
    o_if_gnt    = accept && (cur_owner == OWN_IF);
    o_dm_gnt    = accept && (cur_owner == OWN_DM);
    o_if_rvalid = pop && (head_own == OWN_IF);
    o_dm_rvalid = pop && (head_own == OWN_DM);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_dm_rdata  = (o_dm_rvalid && !head_st) ? i_mem_rdata : '0;
  end

  // In-order tracker of owner id and store flag per outstanding transaction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_own_q[i] <= OWN_DM;
        fifo_st_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_own_q[wr_ptr_q] <= cur_owner;
        fifo_st_q[wr_ptr_q]  <= (cur_owner == OWN_DM) && i_dm_we;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Sticky error on a response that matches no outstanding transaction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (i_mem_rvalid && (count_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
module tb_cpu_mem_arbiter;

  localparam int unsigned MAX_OUT = 2;
`ifndef CPU_MEM_ARB_RR_EN
  localparam int unsigned STARVE_LIM = 3;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req = 1'b0, i_dm_we = 1'b0;
  logic [3:0]  i_dm_be = '0;
  logic [31:0] i_dm_addr = '0, i_dm_wdata = '0;
  logic        o_dm_gnt, o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_err;

  cpu_mem_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt),
    .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic own_if; logic store; } trk_t;
  trk_t m_q[$];
  bit   m_hold, m_hold_if, m_err;
`ifdef CPU_MEM_ARB_RR_EN
  bit   m_last_if;
`else
  int unsigned m_starve;
`endif
  bit   e_req, e_if, e_acc;

  task automatic model_reset();
    m_q.delete();
    m_hold = 0; m_hold_if = 0; m_err = 0;
`ifdef CPU_MEM_ARB_RR_EN
    m_last_if = 1;
`else
    m_starve = 0;
`endif
  endtask

  task automatic model_check();
    trk_t head;
    bit   hit;
    e_req = 0; e_if = 0;
    if (m_hold) begin
      e_req = 1; e_if = m_hold_if;
    end else if (m_q.size() < MAX_OUT && (i_dm_req || i_if_req)) begin
      e_req = 1;
`ifdef CPU_MEM_ARB_RR_EN
      e_if = (i_dm_req && i_if_req) ? !m_last_if : i_if_req;
`else
      e_if = i_if_req && (!i_dm_req || m_starve == STARVE_LIM);
`endif
    end
    e_acc = e_req && i_mem_gnt;
    hit = i_mem_rvalid && (m_q.size() > 0);
    head = '0;
    if (hit) head = m_q[0];
    chk("mem_req",   o_mem_req,   e_req);
    chk("mem_we",    o_mem_we,    e_req && !e_if && i_dm_we);
    chk("mem_be",    o_mem_be,    !e_req ? 4'h0 : (e_if ? 4'hF : i_dm_be));
    chk("mem_addr",  o_mem_addr,  !e_req ? 32'h0 : (e_if ? i_if_addr : i_dm_addr));
    chk("mem_wdata", o_mem_wdata, (e_req && !e_if) ? i_dm_wdata : 32'h0);
    chk("if_gnt",    o_if_gnt,    e_acc && e_if);
    chk("dm_gnt",    o_dm_gnt,    e_acc && !e_if);
    chk("if_rvalid", o_if_rvalid, hit && head.own_if);
    chk("dm_rvalid", o_dm_rvalid, hit && !head.own_if);
    chk("if_rdata",  o_if_rdata,  (hit && head.own_if) ? i_mem_rdata : 32'h0);
    chk("dm_rdata",  o_dm_rdata,  (hit && !head.own_if && !head.store) ? i_mem_rdata : 32'h0);
    chk("err",       o_err,       m_err);
  endtask

  task automatic model_update();
    trk_t t;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    if (i_mem_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (e_acc) begin
      t.own_if = e_if;
      t.store  = !e_if && i_dm_we;
      m_q.push_back(t);
    end
    if (e_req && !i_mem_gnt) m_hold_if = e_if;
    m_hold = e_req && !i_mem_gnt;
`ifdef CPU_MEM_ARB_RR_EN
    if (e_acc) m_last_if = e_if;
`else
    if (!i_if_req || (e_acc && e_if)) m_starve = 0;
    else if (m_starve < STARVE_LIM) m_starve++;
`endif
  endtask

  // ---------------- environment ----------------
  int   mem_out = 0;
  bit   s_if_gnt, s_dm_gnt;
  logic dut_log[$];

  task automatic step();
    @(negedge i_clk);
    model_check();
    s_if_gnt = o_if_gnt;
    s_dm_gnt = o_dm_gnt;
    if (o_if_gnt) dut_log.push_back(1'b1);
    if (o_dm_gnt) dut_log.push_back(1'b0);
    if (i_mem_rvalid && mem_out > 0) mem_out--;
    if (o_mem_req && i_mem_gnt) mem_out++;
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    i_if_req = 0; i_dm_req = 0; i_mem_gnt = 0;
    repeat (6) begin
      i_mem_rvalid = (mem_out > 0);
      i_mem_rdata  = $urandom;
      step();
    end
    i_mem_rvalid = 0;
  endtask

  task automatic do_reset();
    i_if_req = 0; i_dm_req = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
    i_rst_n = 0;
    model_reset();
    mem_out = 0;
    #2;
    chk("rst_err", o_err, 0);
    chk("rst_mem_req", o_mem_req, 0);
    step();
    i_rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_pat [8];
    model_reset();
    // reset state
    repeat (2) step();
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_if_gnt", o_if_gnt, 0);
    chk("rst_dm_gnt", o_dm_gnt, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_err", o_err, 0);
    i_rst_n = 1;
    step();

    // single IF read, response two cycles after accept
    i_if_req = 1; i_if_addr = 32'h40; i_mem_gnt = 1;
    #2;
    chk("t1_if_gnt", o_if_gnt, 1);
    chk("t1_mem_addr", o_mem_addr, 32'h40);
    chk("t1_mem_be", o_mem_be, 4'hF);
    step();
    i_if_req = 0; i_mem_gnt = 0;
    step();
    i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF;
    #2;
    chk("t1_if_rvalid", o_if_rvalid, 1);
    chk("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("t1_dm_rvalid", o_dm_rvalid, 0);
    step();
    i_mem_rvalid = 0;
    step();

    // both requesting, memory always grants and answers next cycle
    dut_log.delete();
    i_dm_req = 1; i_dm_we = 0; i_dm_be = 4'hF; i_dm_addr = $urandom;
    i_if_req = 1; i_if_addr = $urandom; i_mem_gnt = 1;
    repeat (8) begin
      i_mem_rvalid = (mem_out > 0);
      i_mem_rdata  = $urandom;
      step();
      if (s_dm_gnt) i_dm_addr = $urandom;
      if (s_if_gnt) i_if_addr = $urandom;
    end
`ifdef CPU_MEM_ARB_RR_EN
    exp_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    chk("t2_accepts", dut_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_owner%0d", i), (i < dut_log.size()) ? dut_log[i] : 1'bx, exp_pat[i]);
    drain();

    // DM store held while memory stalls, IF waiting behind it
    i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h100; i_dm_wdata = 32'h12345678; i_dm_be = 4'b0011;
    i_if_req = 1; i_if_addr = 32'h200; i_mem_gnt = 0;
    repeat (3) begin
      #2;
      chk("t3_hold_req", o_mem_req, 1);
      chk("t3_hold_addr", o_mem_addr, 32'h100);
      chk("t3_hold_wdata", o_mem_wdata, 32'h12345678);
      chk("t3_hold_be", o_mem_be, 4'b0011);
      chk("t3_hold_we", o_mem_we, 1);
      chk("t3_hold_dm_gnt", o_dm_gnt, 0);
      chk("t3_hold_if_gnt", o_if_gnt, 0);
      step();
    end
    i_mem_gnt = 1;
    #2;
    chk("t3_dm_gnt", o_dm_gnt, 1);
    chk("t3_gnt_addr", o_mem_addr, 32'h100);
    step();
    i_dm_req = 0; i_dm_we = 0;
    #2;
    chk("t3_if_addr", o_mem_addr, 32'h200);
    chk("t3_if_gnt", o_if_gnt, 1);
    step();
    i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    #2;
    chk("t3_st_rvalid", o_dm_rvalid, 1);
    chk("t3_st_rdata", o_dm_rdata, 0);
    chk("t3_st_if_rvalid", o_if_rvalid, 0);
    step();
    i_mem_rdata = 32'h000055AA;
    #2;
    chk("t3_if_rvalid", o_if_rvalid, 1);
    chk("t3_if_rdata", o_if_rdata, 32'h000055AA);
    step();
    i_mem_rvalid = 0;
    step();

    // outstanding limit with withheld responses
    i_dm_req = 1; i_dm_we = 0; i_dm_be = 4'hF; i_dm_addr = 32'h300; i_mem_gnt = 1;
    repeat (2) begin
      #2;
      chk("t4_dm_gnt", o_dm_gnt, 1);
      step();
    end
    #2;
    chk("t4_full_req", o_mem_req, 0);
    step();
    i_mem_rvalid = 1; i_mem_rdata = $urandom;
    #2;
    chk("t4_rv_same_req", o_mem_req, 0);
    chk("t4_rv_dm", o_dm_rvalid, 1);
    step();
    i_mem_rvalid = 0;
    #2;
    chk("t4_next_req", o_mem_req, 1);
    chk("t4_next_gnt", o_dm_gnt, 1);
    step();
    drain();

    // stray response: dropped, sticky error until reset
    i_mem_rvalid = 1; i_mem_rdata = 32'h1234;
    #2;
    chk("t5_if_rvalid", o_if_rvalid, 0);
    chk("t5_dm_rvalid", o_dm_rvalid, 0);
    step();
    i_mem_rvalid = 0;
    repeat (3) begin
      #2;
      chk("t5_err_sticky", o_err, 1);
      step();
    end
    do_reset();
    step();
    chk("t5_err_cleared", o_err, 0);
    i_mem_rvalid = 1;
    step();
    i_mem_rvalid = 0;
    #2;
    chk("t5_late_err", o_err, 1);
    step();

    // mid-stream reset, then first accept is DM
    do_reset();
    i_dm_req = 1; i_dm_we = 0; i_if_req = 1; i_mem_gnt = 1;
    repeat (3) begin
      i_mem_rvalid = (mem_out > 0);
      i_mem_rdata  = $urandom;
      step();
    end
    do_reset();
    chk("t6_if_gnt_rst", o_if_gnt, 0);
    chk("t6_dm_rvalid_rst", o_dm_rvalid, 0);
    i_dm_req = 1; i_if_req = 1; i_mem_gnt = 1;
    #2;
    chk("t6_first_dm", o_dm_gnt, 1);
    chk("t6_first_not_if", o_if_gnt, 0);
    step();
    drain();

    // random traffic
    repeat (400) begin
      if (!i_if_req || s_if_gnt) begin
        i_if_req  = ($urandom_range(0, 2) != 0);
        i_if_addr = $urandom;
      end
      if (!i_dm_req || s_dm_gnt) begin
        i_dm_req   = ($urandom_range(0, 2) != 0);
        i_dm_we    = $urandom_range(0, 1);
        i_dm_be    = $urandom_range(0, 15);
        i_dm_addr  = $urandom;
        i_dm_wdata = $urandom;
      end
      i_mem_gnt    = ($urandom_range(0, 3) != 0);
      i_mem_rvalid = (mem_out > 0) && ($urandom_range(0, 1) == 1);
      i_mem_rdata  = $urandom;
      step();
    end
    i_mem_gnt = 1; i_mem_rvalid = 0;
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
